// File: rtl/grain_pkg.sv
// grain_pkg
//   Shared definitions for the Grain-style link: core register widths, the
//   receive FSM state encoding, feedback tap positions and the keystream,
//   LFSR-feedback and NFSR-feedback functions. Both the transmit and receive
//   ends must evaluate exactly these functions to stay bit-synchronous.
package grain_pkg;

  localparam int LFSR_W = 80;
  localparam int NFSR_W = 24;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    WARMUP = 3'd2,
    ACCEPT = 3'd3,
    SHIFT  = 3'd4,
    OUT    = 3'd5
  } state_e;

  // Linear LFSR feedback taps.
  localparam int FL_TAP [6] = '{0, 13, 23, 38, 51, 62};

  // Keystream bit. N0 appears twice and cancels; the term list is kept as
  // the shared definition so both ends are obviously identical.
  function automatic logic grain_z(input logic [LFSR_W-1:0] l,
                                   input logic [NFSR_W-1:0] n);
    return l[0] ^ l[3] ^ n[0] ^ n[2] ^ (l[1] & l[2]) ^ (n[1] & l[5]) ^
           (n[3] & l[7]) ^ (l[8] & l[13] & n[5]) ^ n[0];
  endfunction

  function automatic logic grain_fl(input logic [LFSR_W-1:0] l);
    logic f;
    f = 1'b0;
    for (int i = 0; i < 6; i++) f ^= l[FL_TAP[i]];
    return f;
  endfunction

  function automatic logic grain_fn(input logic [LFSR_W-1:0] l,
                                    input logic [NFSR_W-1:0] n);
    return l[0] ^ n[0] ^ n[9] ^ (n[14] & n[21]) ^ (n[3] & n[17]);
  endfunction

endpackage

// File: rtl/grain_keystream_core.sv
// grain_keystream_core
//   80-bit LFSR + 24-bit NFSR keystream generator, shared by both link ends.
//   Ports:
//     Clk, reset   clock (rising edge), asynchronous active-low reset
//     load         load seed_l/seed_n into L/N this cycle (wins over step)
//     step         advance both registers one step
//     seed_l/n     seeds
//     z            keystream bit derived from the current (pre-step) state
//     L, N         current register contents
module grain_keystream_core
  import grain_pkg::*;
(
  input  logic              Clk,
  input  logic              reset,
  input  logic              load,
  input  logic              step,
  input  logic [LFSR_W-1:0] seed_l,
  input  logic [NFSR_W-1:0] seed_n,
  output logic              z,
  output logic [LFSR_W-1:0] L,
  output logic [NFSR_W-1:0] N
);

  logic [LFSR_W-1:0] l_q, l_d;
  logic [NFSR_W-1:0] n_q, n_d;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    l_d = l_q;
    n_d = n_q;
    if (load) begin
      l_d = seed_l;
      n_d = seed_n;
    end else if (step) begin
      l_d = {grain_fl(l_q), l_q[LFSR_W-1:1]};
      n_d = {grain_fn(l_q, n_q), n_q[NFSR_W-1:1]};
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      l_q <= '0;
      n_q <= '0;
    end else begin
      l_q <= l_d;
      n_q <= n_d;
    end
  end

  assign z = grain_z(l_q, n_q);
  assign L = l_q;
  assign N = n_q;

endmodule

// File: rtl/grain_stream_decryptor.sv
// grain_stream_decryptor
//   Receive end of the Grain link. Re-keys on start, discards WARMUP_CYCLES
//   keystream bits, then XORs each accepted ciphertext byte LSB first with
//   the keystream and presents the plaintext byte.
//   Ports:
//     Clk, reset        clock (rising edge), asynchronous active-low reset
//     start             re-key pulse, honoured in IDLE and ACCEPT only
//     seed_l, seed_n    core seeds, sampled when start is honoured
//     s_valid/s_ready/s_data   ciphertext input stream
//     m_valid/m_ready/m_data   plaintext output stream
//     busy              high in LOAD, WARMUP and SHIFT
//     keyed             high once warm-up has completed
module grain_stream_decryptor
  import grain_pkg::*;
#(
  parameter int DATA_W        = 8,
  parameter int WARMUP_CYCLES = 160
) (
  input  logic              Clk,
  input  logic              reset,
  input  logic              start,
  input  logic [LFSR_W-1:0] seed_l,
  input  logic [NFSR_W-1:0] seed_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              busy,
  output logic              keyed
);

  localparam int WCNT_W = (WARMUP_CYCLES > 0) ? $clog2(WARMUP_CYCLES + 1) : 1;
  localparam int BCNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [WCNT_W-1:0] WCNT_LAST =
    WCNT_W'((WARMUP_CYCLES > 0) ? WARMUP_CYCLES - 1 : 0);
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(DATA_W - 1);

  state_e            state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [BCNT_W-1:0] bcnt_q, bcnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              keyed_q, keyed_d;

  logic              start_ok;
  logic              core_step;
  logic              z;
  logic [LFSR_W-1:0] unused_l;
  logic [NFSR_W-1:0] unused_n;

  // The seeds go straight into the core on the honoured start cycle; LOAD is
  // then a hold cycle that clears the counter, giving the same keystream as
  // loading in LOAD while sampling the seed ports when start is accepted.
  assign start_ok  = start && (state_q == IDLE || state_q == ACCEPT);
  assign core_step = (state_q == WARMUP) || (state_q == SHIFT);

  grain_keystream_core u_core (
    .Clk    (Clk),
    .reset  (reset),
    .load   (start_ok),
    .step   (core_step),
    .seed_l (seed_l),
    .seed_n (seed_n),
    .z      (z),
    .L      (unused_l),
    .N      (unused_n)
  );

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    bcnt_d  = bcnt_q;
    data_d  = data_q;
    keyed_d = keyed_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          keyed_d = 1'b0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        wcnt_d = '0;
        if (WARMUP_CYCLES == 0) begin
          keyed_d = 1'b1;
          state_d = ACCEPT;
        end else begin
          state_d = WARMUP;
        end
      end
      WARMUP: begin
        if (wcnt_q == WCNT_LAST) begin
          keyed_d = 1'b1;
          state_d = ACCEPT;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      ACCEPT: begin
        // A re-key wins over a byte offered in the same cycle.
        if (start) begin
          keyed_d = 1'b0;
          state_d = LOAD;
        end else if (s_valid) begin
          data_d  = s_data;
          bcnt_d  = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // Decrypt the LSB and rotate it in at the top; after DATA_W steps
        // the register holds the plaintext in the original bit order.
        data_d = {data_q[0] ^ z, data_q[DATA_W-1:1]};
        if (bcnt_q == BCNT_LAST) state_d = OUT;
        else                     bcnt_d  = bcnt_q + 1'b1;
      end
      OUT: begin
        if (m_ready) state_d = ACCEPT;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      bcnt_q  <= '0;
      data_q  <= '0;
      keyed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      bcnt_q  <= bcnt_d;
      data_q  <= data_d;
      keyed_q <= keyed_d;
    end
  end

  // Outputs decode registered state only; nothing passes m_ready through.
  assign s_ready = (state_q == ACCEPT);
  assign m_valid = (state_q == OUT);
  assign busy    = (state_q == LOAD) || (state_q == WARMUP) || (state_q == SHIFT);
  assign keyed   = keyed_q;
  assign m_data  = data_q;

endmodule

// File: tb/tb_grain_stream_decryptor.sv
// tb_grain_stream_decryptor
//   Self-checking bench: a behavioural keystream model encrypts plaintext,
//   expected plaintext is queued when each byte is driven and compared when
//   the decryptor hands it out.
module tb_grain_stream_decryptor;

  localparam int DATA_W = 8;
  localparam int WARMUP = 160;

  logic        Clk = 1'b0;
  logic        reset, start, s_valid, s_ready, m_valid, m_ready, busy, keyed;
  logic [79:0] seed_l;
  logic [23:0] seed_n;
  logic [7:0]  s_data, m_data;

  int errors  = 0;
  int checks  = 0;
  int cyc     = 0;
  int hs_edge = 0;

  logic [79:0] ml;
  logic [23:0] mn;
  logic [7:0]  exp_q[$];

  always #5 Clk = ~Clk;

  grain_stream_decryptor #(.DATA_W(DATA_W), .WARMUP_CYCLES(WARMUP)) dut (
    .Clk     (Clk),
    .reset   (reset),
    .start   (start),
    .seed_l  (seed_l),
    .seed_n  (seed_n),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .busy    (busy),
    .keyed   (keyed)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge Clk);
    #1;
    cyc++;
  endtask

  // Behavioural keystream generator (transmit side).
  task automatic model_step(output logic z);
    logic fl, fn;
    z  = ml[0] ^ ml[3] ^ mn[0] ^ mn[2] ^ (ml[1] & ml[2]) ^ (mn[1] & ml[5]) ^
         (mn[3] & ml[7]) ^ (ml[8] & ml[13] & mn[5]) ^ mn[0];
    fl = ml[0] ^ ml[13] ^ ml[23] ^ ml[38] ^ ml[51] ^ ml[62];
    fn = ml[0] ^ mn[0] ^ mn[9] ^ (mn[14] & mn[21]) ^ (mn[3] & mn[17]);
    ml = {fl, ml[79:1]};
    mn = {fn, mn[23:1]};
  endtask

  task automatic model_byte(output logic [7:0] k);
    logic z;
    for (int i = 0; i < DATA_W; i++) begin
      model_step(z);
      k[i] = z;
    end
  endtask

  task automatic model_rekey(input logic [79:0] l, input logic [23:0] n);
    logic z;
    ml = l;
    mn = n;
    repeat (WARMUP) model_step(z);
  endtask

  task automatic reset_checks(input string pfx);
    check({pfx, "_s_ready"}, s_ready, 0);
    check({pfx, "_m_valid"}, m_valid, 0);
    check({pfx, "_busy"},    busy,    0);
    check({pfx, "_keyed"},   keyed,   0);
    check({pfx, "_m_data"},  m_data,  0);
  endtask

  // Pulse start (DUT must be in IDLE or ACCEPT), then wait for keyed.
  // keyed must rise 161 clock edges after the edge that samples start.
  task automatic do_start(input logic [79:0] l, input logic [23:0] n);
    int k  = 0;
    int mv = 0;
    seed_l = l;
    seed_n = n;
    start  = 1'b1;
    cycle();
    start   = 1'b0;
    s_valid = 1'b0;
    model_rekey(l, n);
    exp_q.delete();
    check("load_busy",  busy,    1);
    check("load_keyed", keyed,   0);
    check("load_s_rdy", s_ready, 0);
    while (!keyed && k < 1000) begin
      cycle();
      k++;
      if (m_valid) mv++;
    end
    check("keyed_latency", k, WARMUP + 1);
    check("warmup_no_m_valid", mv, 0);
    check("keyed_s_ready", s_ready, 1);
  endtask

  // Offer one ciphertext byte and complete its handshake.
  task automatic push_byte(input logic [7:0] p);
    logic [7:0] k;
    int w = 0;
    model_byte(k);
    s_data  = p ^ k;
    s_valid = 1'b1;
    exp_q.push_back(p);
    while (!s_ready && w < 500) begin
      cycle();
      w++;
    end
    check("s_ready_wait", w < 500, 1);
    hs_edge = cyc + 1;
    cycle();
    s_valid = 1'b0;
  endtask

  // Wait for a plaintext byte, compare, and consume it. The latency count is
  // inclusive of the handshake edge: handshake edge through the edge after
  // which m_valid is high.
  task automatic pop_byte(input bit timed);
    int w = 0;
    m_ready = 1'b1;
    while (!m_valid && w < 500) begin
      cycle();
      w++;
    end
    check("m_valid_wait", w < 500, 1);
    if (timed) check("latency", cyc - hs_edge + 1, DATA_W + 1);
    check("m_data", m_data, exp_q.pop_front());
    cycle();
    m_ready = 1'b0;
  endtask

  // Random valid/ready gaps on both streams.
  task automatic run_stream(input int nbytes);
    int sent = 0, got = 0, budget = 0;
    bit hs_s, hs_m;
    logic [7:0] md, p, k;
    while (got < nbytes && budget < 30000) begin
      if (!s_valid && sent < nbytes && $urandom_range(0, 3) != 0) begin
        p = 8'($urandom());
        model_byte(k);
        s_data  = p ^ k;
        s_valid = 1'b1;
        exp_q.push_back(p);
        sent++;
      end
      m_ready = ($urandom_range(0, 2) != 0);
      hs_s = s_valid && s_ready;
      hs_m = m_valid && m_ready;
      md   = m_data;
      cycle();
      budget++;
      if (hs_s) s_valid = 1'b0;
      if (hs_m) begin
        check("lb_data", md, exp_q.pop_front());
        got++;
      end
    end
    check("lb_count", got, nbytes);
    m_ready = 1'b0;
  endtask

  initial begin
    int mv;
    logic [79:0] rl;
    logic [23:0] rn;

    reset = 1'b0; start = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
    s_data = '0; seed_l = '0; seed_n = '0;
    #1;
    reset_checks("por");
    repeat (3) cycle();
    reset = 1'b1;
    cycle();
    reset_checks("idle");

    // Zero seeds: fixed point, plaintext equals ciphertext.
    do_start(80'h0, 24'h0);
    push_byte(8'hA5); pop_byte(1);
    push_byte(8'h3C); pop_byte(1);

    // Non-trivial seeds, 16 sequential bytes.
    do_start(80'h0123456789ABCDEF0123, 24'hC0FFEE);
    for (int i = 0; i < 16; i++) begin
      push_byte(8'(i));
      pop_byte(1);
    end

    // Back-pressure in OUT for 20 cycles.
    push_byte(8'h5A);
    mv = 0;
    while (!m_valid && mv < 500) begin cycle(); mv++; end
    check("bp_wait", mv < 500, 1);
    repeat (20) begin
      cycle();
      check("bp_m_valid", m_valid, 1);
      check("bp_m_data",  m_data,  exp_q[0]);
      check("bp_s_ready", s_ready, 0);
    end
    pop_byte(0);
    push_byte(8'hC3); pop_byte(1);

    // start during SHIFT is ignored.
    push_byte(8'h77);
    cycle(); cycle();
    seed_l = 80'hFFFF_0000_FFFF_0000_FFFF; seed_n = 24'h123456;
    start = 1'b1;
    cycle();
    start = 1'b0;
    check("shift_start_busy", busy, 1);
    pop_byte(1);
    check("shift_start_keyed", keyed, 1);
    push_byte(8'h81); pop_byte(1);

    // start in ACCEPT with s_valid high: re-key, no byte taken.
    s_data  = 8'hEE;
    s_valid = 1'b1;
    do_start(80'hDEAD_BEEF_0000_1111_2222, 24'h0BADF0);
    push_byte(8'h42); pop_byte(1);

    // Reset during warm-up cycle 50.
    seed_l = 80'h1; seed_n = 24'h1;
    start = 1'b1;
    cycle();
    start = 1'b0;
    repeat (50) cycle();
    reset = 1'b0;
    #1;
    reset_checks("rst_warmup");
    cycle();
    reset = 1'b1;
    mv = 0;
    repeat (10) begin cycle(); if (m_valid) mv++; end
    check("rst_warmup_no_mv", mv, 0);
    reset_checks("rst_warmup_idle");

    // Reset during SHIFT bit 3.
    do_start(80'h0123456789ABCDEF0123, 24'hC0FFEE);
    push_byte(8'h99);
    repeat (3) cycle();
    reset = 1'b0;
    #1;
    reset_checks("rst_shift");
    cycle();
    reset = 1'b1;
    exp_q.delete();
    mv = 0;
    repeat (20) begin cycle(); if (m_valid) mv++; end
    check("rst_shift_no_mv", mv, 0);
    check("rst_shift_idle_s_ready", s_ready, 0);
    check("rst_shift_idle_busy", busy, 0);

    // Loopback with random seeds, bytes and gaps.
    rl = {$urandom(), $urandom(), 16'($urandom())};
    rn = 24'($urandom());
    do_start(rl, rn);
    run_stream(256);
    check("lb_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
